decode_pipe: RTL and testbench

Pipelined, buffered instruction decode stage: the successor to the combinational decoder. Accepts 32-bit instructions over a valid/ready handshake and registers the decoded fields into a DEPTH-entry FIFO. Holds the head entry back on a load-use hazard and supports a synchronous flush. Sits between the fetch stage and the register-file read / execute stage; immediate width is parametrised.

---
 rtl/decode_pipe.sv | 168 ++++++++++++++++
 tb/tb_decode_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// decode_pipe : buffered instruction decode stage with load-use hold and flush
// Optional macro: DECODE_ROTR_SLA_EN (rotr aluop/shamt and sla shamt decode)
// Revision: 1.0
// ============================================================================
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic            flush,
  input  logic            load_pending,
  input  logic [4:0]      load_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_shamt,
  output logic [4:0]      out_aluop,
  output logic [XLEN-1:0] out_imm,
  output logic            hazard_stall
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [4:0] C_OP_BNE  = 5'b00010;
  localparam logic [4:0] C_OP_JAL  = 5'b00011;
  localparam logic [4:0] C_OP_JR   = 5'b00100;
  localparam logic [4:0] C_OP_ADDI = 5'b00101;
  localparam logic [4:0] C_OP_BLT  = 5'b00110;
  localparam logic [4:0] C_OP_SW   = 5'b00111;
  localparam logic [4:0] C_OP_LW   = 5'b01000;
  localparam logic [4:0] C_OP_SETX = 5'b10101;
  localparam logic [4:0] C_OP_BEX  = 5'b10110;
`ifdef DECODE_ROTR_SLA_EN
  localparam logic [4:0] C_OP_ROTR = 5'b11101;
  localparam logic [4:0] C_ALU_SLA = 5'b01011;
`endif

  typedef struct packed {
    logic [4:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      shamt;
    logic [4:0]      aluop;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          dec;
  entry_t          head;
  logic [4:0]      opc;
  logic            is_itype;
  logic            hazard;
  logic            push;
  logic            pop;

  // Combinational decode of the offered word; only captured on push.
  always_comb begin
    dec      = '0;
    opc      = in_insn[31:27];
    is_itype = (opc == C_OP_ADDI) || (opc == C_OP_SW) || (opc == C_OP_LW) ||
               (opc == C_OP_BNE)  || (opc == C_OP_BLT);

    dec.opcode = opc;
    dec.imm    = is_itype ? XLEN'($signed(in_insn[16:0])) : XLEN'(in_insn[26:0]);

    if (opc == C_OP_JAL)       dec.rd = 5'd31;
    else if (opc == C_OP_SETX) dec.rd = 5'd30;
    else                       dec.rd = in_insn[26:22];

    if (opc == C_OP_BEX)                                         dec.rs = 5'd30;
    else if ((opc == C_OP_BNE) || (opc == C_OP_BLT) || (opc == C_OP_JR)) dec.rs = in_insn[26:22];
    else                                                         dec.rs = in_insn[21:17];

    if (opc == C_OP_SW)                                          dec.rt = in_insn[26:22];
    else if (opc == C_OP_BEX)                                    dec.rt = 5'd0;
    else if ((opc == C_OP_LW) || (opc == C_OP_BNE) || (opc == C_OP_BLT)) dec.rt = in_insn[21:17];
    else                                                         dec.rt = in_insn[16:12];

    if ((opc == C_OP_BLT) || (opc == C_OP_BNE) || (opc == C_OP_BEX)) dec.aluop = 5'b00001;
    else if (is_itype)                                           dec.aluop = 5'b00000;
    else                                                         dec.aluop = in_insn[6:2];

    dec.shamt = in_insn[11:7];
`ifdef DECODE_ROTR_SLA_EN
    if (opc == C_OP_ROTR) begin
      dec.aluop = 5'b01001;
      dec.shamt = in_insn[4:0];
    end
    // Shift-left-arithmetic takes its amount from the rt register field.
    if (dec.aluop == C_ALU_SLA) dec.shamt = dec.rt;
`endif
  end

  assign head   = mem_q[rptr_q];
  assign hazard = load_pending && (load_rd != 5'd0) && (count_q != '0) &&
                  ((head.rs == load_rd) || (head.rt == load_rd));

  assign in_ready     = (count_q < C_DEPTH) && !flush;
  assign out_valid    = (count_q != '0) && !hazard;
  assign hazard_stall = hazard;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready && !flush;

  assign out_opcode = head.opcode;
  assign out_rd     = head.rd;
  assign out_rs     = head.rs;
  assign out_rt     = head.rt;
  assign out_shamt  = head.shamt;
  assign out_aluop  = head.aluop;
  assign out_imm    = head.imm;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= dec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_pipe : directed self-checking bench for decode_pipe
// Honours DECODE_ROTR_SLA_EN when the design is built with it.
// Revision: 1.0
// ============================================================================
module tb_decode_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic            flush;
  logic            load_pending;
  logic [4:0]      load_rd;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop;
  logic [XLEN-1:0] out_imm;
  logic            hazard_stall;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .flush(flush), .load_pending(load_pending), .load_rd(load_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_shamt(out_shamt), .out_aluop(out_aluop), .out_imm(out_imm),
    .hazard_stall(hazard_stall)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]      opc, rd, rs, rt, shamt, aluop;
    logic [XLEN-1:0] imm;
  } ent_t;

  ent_t mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the field rules.
  function automatic ent_t model_dec(input logic [31:0] w);
    ent_t   e;
    logic [4:0] op;
    bit     itype;
    longint v;
    op    = w[31:27];
    itype = (op == 5) || (op == 7) || (op == 8) || (op == 2) || (op == 6);
    e.opc = op;
    v = itype ? longint'(w[16:0]) : longint'(w[26:0]);
    if (itype && w[16]) v = v - (longint'(1) << 17);
    e.imm = v[XLEN-1:0];
    case (op)
      5'd3:    e.rd = 5'd31;
      5'd21:   e.rd = 5'd30;
      default: e.rd = w[26:22];
    endcase
    if (op == 22)                         e.rs = 5'd30;
    else if (op == 2 || op == 6 || op == 4) e.rs = w[26:22];
    else                                  e.rs = w[21:17];
    if (op == 7)                          e.rt = w[26:22];
    else if (op == 22)                    e.rt = 5'd0;
    else if (op == 8 || op == 2 || op == 6) e.rt = w[21:17];
    else                                  e.rt = w[16:12];
    if (op == 6 || op == 2 || op == 22)   e.aluop = 5'd1;
    else if (itype)                       e.aluop = 5'd0;
    else                                  e.aluop = w[6:2];
    e.shamt = w[11:7];
`ifdef DECODE_ROTR_SLA_EN
    if (op == 29) begin e.aluop = 5'd9; e.shamt = w[4:0]; end
    if (e.aluop == 5'd11) e.shamt = e.rt;
`endif
    return e;
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [16:0] lo);
    return {op, a, b, lo};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh, input logic [4:0] alu);
    return {op, rd, rs, rt, sh, alu, 2'b00};
  endfunction

  // Compare against the queue model on every falling edge, then advance the model
  // to the state the coming rising edge will produce.
  initial begin : compare
    bit   exp_ready, exp_haz, exp_valid;
    ent_t h;
    forever begin
      @(negedge clock);
      exp_ready = (mq.size() < DEPTH) && !flush;
      exp_haz   = 1'b0;
      if (mq.size() != 0) begin
        h = mq[0];
        exp_haz = load_pending && (load_rd != 0) && (h.rs == load_rd || h.rt == load_rd);
      end
      exp_valid = (mq.size() != 0) && !exp_haz;
      if (chk_en) begin
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_valid);
        check("hazard_stall", hazard_stall, exp_haz);
        if (mq.size() != 0) begin
          check("opcode", out_opcode, h.opc);
          check("rd", out_rd, h.rd);
          check("rs", out_rs, h.rs);
          check("rt", out_rt, h.rt);
          check("shamt", out_shamt, h.shamt);
          check("aluop", out_aluop, h.aluop);
          check("imm", out_imm, h.imm);
        end
      end
      if (reset || flush) mq.delete();
      else begin
        if (exp_valid && out_ready) void'(mq.pop_front());
        if (in_valid && exp_ready) mq.push_back(model_dec(in_insn));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] w_a, w_b, w_c, w_d, w_d2, w_hz, w_sla;
  logic [31:0] stream [5];

  initial begin : stim
    w_a  = mk_i(5'b01000, 5'd4, 5'd6, 17'h1FFFF);
    w_b  = mk_i(5'b00111, 5'd7, 5'd8, 17'h00004);
    w_c  = 32'hB0000123;
    w_d  = mk_r(5'b00001, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16);
    w_d2 = 32'hA8000005;
    w_hz = mk_i(5'b00101, 5'd1, 5'd5, 17'h00010);
    w_sla = mk_r(5'b00000, 5'd5, 5'd6, 5'd7, 5'd3, 5'b01011);
    stream[0] = 32'hA8000005;
    stream[1] = mk_i(5'b00010, 5'd3, 5'd4, 17'h1F000);
    stream[2] = mk_i(5'b00110, 5'd9, 5'd10, 17'h00010);
    stream[3] = mk_i(5'b00100, 5'd2, 5'd0, 17'h00000);
    stream[4] = w_sla;

    reset = 1; in_valid = 0; in_insn = 0; flush = 0;
    load_pending = 0; load_rd = 0; out_ready = 0;
    tick(); tick();
    reset = 0; chk_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_hazard", hazard_stall, 0);
    check("rst_opcode", out_opcode, 0);
    check("rst_imm", out_imm, 0);
    check("rst_in_ready", in_ready, 1);

    // addi then jal with one-cycle latency
    out_ready = 1; in_valid = 1; in_insn = 32'h28C5FFFF;
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_opcode", out_opcode, 5'b00101);
    check("addi_rd", out_rd, 3);
    check("addi_rs", out_rs, 2);
    check("addi_aluop", out_aluop, 0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    in_insn = 32'h18000100;
    tick();
    in_valid = 0;
    check("jal_rd", out_rd, 31);
    check("jal_imm", out_imm, 32'h00000100);
    check("jal_aluop", out_aluop, 0);
    tick();

    // load-use hazard on rs
    load_pending = 1; load_rd = 5; in_valid = 1; in_insn = w_hz;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("hz_valid_low", out_valid, 0);
      check("hz_stall", hazard_stall, 1);
      tick();
    end
    load_pending = 0; #1;
    check("hz_release", out_valid, 1);
    tick();

    // load_rd = 0 never stalls
    load_pending = 1; load_rd = 0; in_valid = 1; in_insn = 32'h18000100;
    tick();
    in_valid = 0;
    check("hz_rd0_valid", out_valid, 1);
    check("hz_rd0_stall", hazard_stall, 0);
    tick();

    // hazard through rt, released by load_rd changing
    load_rd = 7; in_valid = 1; in_insn = w_b;
    tick();
    in_valid = 0;
    check("hz_rt_stall", hazard_stall, 1);
    load_rd = 9; #1;
    check("hz_rd_change", out_valid, 1);
    tick();
    load_pending = 0;

    // backpressure and full recovery
    out_ready = 0; in_valid = 1; in_insn = w_a;
    tick();
    in_insn = w_b;
    tick();
    in_insn = w_c; #1;
    check("bp_full", in_ready, 0);
    check("bp_head_a", out_opcode, 5'b01000);
    tick();
    check("bp_held", in_ready, 0);
    out_ready = 1; #1;
    check("bp_full_pop", in_ready, 0);
    tick();
    check("bp_head_b", out_opcode, 5'b00111);
    check("bp_ready_back", in_ready, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      in_insn = stream[i];
      tick();
    end
    in_valid = 0;
    tick(); tick();

    // flush with two entries buffered
    out_ready = 0; in_valid = 1; in_insn = stream[0];
    tick();
    in_insn = stream[1];
    tick();
    in_insn = w_d; flush = 1; #1;
    check("fl_ready", in_ready, 0);
    tick();
    flush = 0; #1;
    check("fl_valid", out_valid, 0);
    check("fl_ready_after", in_ready, 1);
    tick();
    check("fl_push_valid", out_valid, 1);
    check("fl_push_rd", out_rd, 12);
    in_valid = 0; out_ready = 1;
    tick();

    // flush with one entry buffered, where only flush can hold in_ready low
    out_ready = 0; in_valid = 1; in_insn = stream[2];
    tick();
    flush = 1; in_insn = w_d2; #1;
    check("fl1_ready", in_ready, 0);
    tick();
    flush = 0; in_valid = 0; #1;
    check("fl1_valid", out_valid, 0);

    // reset mid-stream
    in_valid = 1; in_insn = w_a;
    tick();
    in_insn = w_b;
    tick();
    in_insn = w_c; reset = 1;
    tick();
    reset = 0; in_valid = 0;
    check("mrst_valid", out_valid, 0);
    check("mrst_opcode", out_opcode, 0);
    check("mrst_imm", out_imm, 0);
    check("mrst_ready", in_ready, 1);

    // rotr and sla decode
    out_ready = 1; in_valid = 1; in_insn = 32'hE8000007;
    tick();
    in_valid = 0;
`ifdef DECODE_ROTR_SLA_EN
    check("rotr_aluop", out_aluop, 5'b01001);
    check("rotr_shamt", out_shamt, 7);
`else
    check("rotr_aluop", out_aluop, 5'b00001);
    check("rotr_shamt", out_shamt, 0);
`endif
    tick();
    in_valid = 1; in_insn = w_sla;
    tick();
    in_valid = 0;
    check("sla_aluop", out_aluop, 5'b01011);
`ifdef DECODE_ROTR_SLA_EN
    check("sla_shamt", out_shamt, 7);
`else
    check("sla_shamt", out_shamt, 3);
`endif
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
